// File: rtl/lc3_mem_arbiter.sv
// Shares one single-port memory between the LC3 fetch and data ports (data has priority).
// Optional STARVE_GUARD_EN: caps consecutive data grants while a fetch is waiting.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic              Data_rd,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StInstr, StData} state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            starve_hit;
  logic            grant_data;
  logic            grant_instr;
  logic            access_done;

`ifdef STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt_q;
  assign starve_hit = (starve_cnt_q >= SW'(STARVE_MAX)) && instrmem_rd;
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    grant_data  = data_req && !starve_hit;
    grant_instr = instrmem_rd && !grant_data;
    // The last waiting cycle aborts unless the ack arrives in it.
    access_done = mem_ack || (wait_cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      timeout_err    <= 1'b0;
`ifdef STARVE_GUARD_EN
      starve_cnt_q   <= '0;
`endif
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wait_cnt_q <= '0;
          if (grant_data) begin
            state_q   <= StData;
            mem_req   <= 1'b1;
            mem_we    <= !Data_rd;
            mem_addr  <= Data_addr;
            mem_wdata <= Data_din;
`ifdef STARVE_GUARD_EN
            starve_cnt_q <= instrmem_rd ? starve_cnt_q + SW'(1) : '0;
`endif
          end else if (grant_instr) begin
            state_q  <= StInstr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
`ifdef STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
          end
        end
        StInstr, StData: begin
          if (access_done) begin
            state_q    <= StIdle;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            wait_cnt_q <= '0;
            if (state_q == StInstr) complete_instr <= 1'b1;
            else                    complete_data  <= 1'b1;
            if (mem_ack) begin
              if (state_q == StInstr) Instr_dout <= mem_rdata;
              else if (!mem_we)       Data_dout  <= mem_rdata;
            end else begin
              timeout_err <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_lc3_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 64;
  localparam int unsigned SM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          instrmem_rd;
  logic [DW-1:0] Instr_dout;
  logic          complete_instr;
  logic          data_req;
  logic [AW-1:0] Data_addr;
  logic          Data_rd;
  logic [DW-1:0] Data_din;
  logic [DW-1:0] Data_dout;
  logic          complete_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          timeout_err;

  lc3_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO),
    .STARVE_MAX(SM)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .instrmem_rd   (instrmem_rd),
    .Instr_dout    (Instr_dout),
    .complete_instr(complete_instr),
    .data_req      (data_req),
    .Data_addr     (Data_addr),
    .Data_rd       (Data_rd),
    .Data_din      (Data_din),
    .Data_dout     (Data_dout),
    .complete_data (complete_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
    ,.timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, described by who owns it and its fields.
  bit            m_busy;
  bit            m_is_data;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_high;
  bit            m_ci, m_cd, m_terr;
  logic [DW-1:0] m_idout, m_ddout;
  int            m_starve;

  task automatic model_update();
    bit take_i;
    m_ci = 0;
    m_cd = 0;
    if (!reset) begin
      m_busy = 0; m_we = 0; m_terr = 0; m_starve = 0; m_high = 0;
      m_idout = '0; m_ddout = '0;
    end else if (m_busy) begin
      m_high++;
      if (mem_ack || m_high == TO) begin
        if (m_is_data) m_cd = 1; else m_ci = 1;
        if (!mem_ack) m_terr = 1;
        else if (!m_is_data) m_idout = mem_rdata;
        else if (!m_we) m_ddout = mem_rdata;
        m_busy = 0;
      end
    end else if (data_req || instrmem_rd) begin
      take_i = instrmem_rd && !data_req;
`ifdef STARVE_GUARD_EN
      if (instrmem_rd && m_starve >= SM) take_i = 1;
`endif
      m_busy = 1;
      m_high = 0;
      m_is_data = !take_i;
      if (take_i) begin
        m_we = 0; m_addr = pc; m_starve = 0;
      end else begin
        m_we = !Data_rd; m_addr = Data_addr; m_wdata = Data_din;
        m_starve = instrmem_rd ? m_starve + 1 : 0;
      end
    end
  endtask

  // Memory responder: ack_lat >= 0 fixed wait, -1 never, -2 random (with spurious idle acks).
  logic [DW-1:0] mem [256];
  int  ack_lat = 0;
  int  req_age = 0;
  bit  stall;
  bit  resp_en = 1;

  task automatic respond();
    bit fire;
    if (!resp_en) return;
    mem_ack   = 1'b0;
    mem_rdata = DW'($urandom);
    if (mem_req) begin
      if (req_age == 0) stall = (ack_lat == -2) && ($urandom_range(0, 49) == 0);
      if (ack_lat == -2) fire = !stall && ($urandom_range(0, 2) == 0);
      else               fire = (ack_lat >= 0) && (req_age == ack_lat);
      req_age++;
      if (fire) begin
        mem_ack = 1'b1;
        req_age = 0;
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[7:0]];
      end
    end else begin
      req_age = 0;
      if (ack_lat == -2) mem_ack = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check_eq("mem_req", mem_req, m_busy);
    check_eq("mem_we", mem_we, m_busy && m_we);
    if (m_busy) check_eq("mem_addr", mem_addr, m_addr);
    if (m_busy && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("complete_instr", complete_instr, m_ci);
    check_eq("complete_data", complete_data, m_cd);
    check_eq("Instr_dout", Instr_dout, m_idout);
    check_eq("Data_dout", Data_dout, m_ddout);
    check_eq("timeout_err", timeout_err, m_terr);
    respond();
  endtask

  task automatic go_idle(input int n);
    instrmem_rd = 0;
    data_req    = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  int lat, cnt, t_d, t_i, n_i, n_d;
  logic [DW-1:0] saved;
  bit order_ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    reset = 0; pc = '0; instrmem_rd = 1; data_req = 0; Data_addr = '0; Data_rd = 1;
    Data_din = '0; mem_rdata = '0; mem_ack = 1;

    // Reset held with a fetch pending and a stray ack.
    resp_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_mem_req", mem_req, 0);
    end
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_terr", timeout_err, 0);
    reset = 1; mem_ack = 0; resp_en = 1;
    go_idle(2);

    // Single fetch acked in its first request cycle.
    ack_lat = 0;
    mem[8'h00] = 16'h1234;
    pc = 16'h3000; instrmem_rd = 1;
    lat = 0;
    do begin step(); lat++; end while (!complete_instr && lat < 10);
    instrmem_rd = 0;
    check_eq("fetch_latency", lat, 2);
    check_eq("fetch_dout", Instr_dout, 16'h1234);
    go_idle(2);

    // Write with three request cycles before the ack.
    ack_lat = 2;
    saved = Data_dout;
    data_req = 1; Data_rd = 0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
    cnt = 0; lat = 0;
    do begin
      step(); lat++;
      if (mem_req && mem_we && mem_addr == 16'h4000 && mem_wdata == 16'hBEEF) cnt++;
    end while (!complete_data && lat < 20);
    data_req = 0;
    check_eq("write_we_cycles", cnt, 3);
    check_eq("write_dout_kept", Data_dout, saved);
    step();
    check_eq("write_pulse_1cyc", complete_data, 0);
    go_idle(2);

    // Both requests rising together: data first, one turnaround, then fetch.
    ack_lat = 1;
    Data_rd = 1; Data_addr = 16'h0042; pc = 16'h3001;
    data_req = 1; instrmem_rd = 1;
    t_d = -1; t_i = -1;
    for (int i = 0; i < 30 && t_i < 0; i++) begin
      step();
      if (complete_data)  begin t_d = i; data_req = 0; end
      if (complete_instr) begin t_i = i; instrmem_rd = 0; end
    end
    order_ok = (t_d >= 0) && (t_i > t_d);
    check_eq("contention_order", order_ok, 1);
    check_eq("contention_gap", t_i - t_d, 3);
    go_idle(2);

    // Timeout: memory never answers.
    ack_lat = -1;
    saved = Instr_dout;
    pc = 16'h3002; instrmem_rd = 1;
    cnt = 0; lat = 0;
    do begin step(); lat++; if (mem_req) cnt++; end while (!complete_instr && lat < 200);
    instrmem_rd = 0;
    check_eq("timeout_req_cycles", cnt, TO);
    check_eq("timeout_err_set", timeout_err, 1);
    check_eq("timeout_dout_kept", Instr_dout, saved);
    go_idle(5);
    check_eq("timeout_err_sticky", timeout_err, 1);
    reset = 0; step(); reset = 1;
    check_eq("timeout_err_cleared", timeout_err, 0);
    go_idle(2);

    // Both requests held: grant order under sustained contention.
    ack_lat = 0;
    data_req = 1; instrmem_rd = 1; Data_rd = 1;
    n_i = 0; n_d = 0; order_ok = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (complete_data || complete_instr) begin
`ifdef STARVE_GUARD_EN
        if (complete_instr != ((n_i + n_d) % (SM + 1) == SM)) order_ok = 0;
`else
        if (complete_instr) order_ok = 0;
`endif
        if (complete_instr) n_i++; else n_d++;
      end
    end
    check_eq("starve_order", order_ok, 1);
    check_eq("starve_progress", (n_i + n_d) >= 15, 1);
    go_idle(2);

    // Randomized traffic against the model.
    ack_lat = -2;
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 299) != 0);
      if (!instrmem_rd || complete_instr) begin
        instrmem_rd = ($urandom_range(0, 2) != 0);
        pc = AW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        pc = AW'($urandom);
      end
      if (!data_req || complete_data) begin
        data_req  = ($urandom_range(0, 1) != 0);
        Data_addr = AW'($urandom);
        Data_rd   = $urandom_range(0, 1) != 0;
        Data_din  = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        Data_addr = AW'($urandom);
        Data_din  = DW'($urandom);
      end
    end
    reset = 1;
    go_idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Shares one single-port unified memory between the LC3 instruction-fetch port and the LC3 data port. It arbitrates between the two ports, runs a request/ack handshake with the memory, and returns results through the LC3 completion strobes, complete_instr and complete_data. It sits between the LC3 core and the memory model or SRAM wrapper, in place of two independent memories.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 64, cycles to wait for mem_ack before aborting an access (minimum 2)
STARVE_MAX, 4, consecutive data grants allowed while a fetch is waiting (used only with the optional feature)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
pc  input  ADDR_W  fetch address
instrmem_rd  input  1  fetch request, level
Instr_dout  output  DATA_W  fetched instruction word
complete_instr  output  1  one-cycle fetch-done pulse
data_req  input  1  data access request, level
Data_addr  input  ADDR_W  data address
Data_rd  input  1  1 = read, 0 = write
Data_din  input  DATA_W  write data from the core
Data_dout  output  DATA_W  read data to the core
complete_data  output  1  one-cycle data-done pulse
mem_req  output  1  memory request, held until ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  one-cycle access-done pulse
timeout_err  output  1  sticky error flag

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE. All outputs are 0, including Instr_dout, Data_dout and timeout_err. The timeout counter is cleared.
- Reset asserted mid-access abandons the access. No complete_* pulse is issued for it. A late mem_ack after reset is ignored in IDLE.
- FSM states: IDLE, INSTR, DATA.
- IDLE, cycle N:
  - if data_req=1: go to DATA; otherwise if instrmem_rd=1: go to INSTR.
  - Data has priority, because a data access stalls an older instruction.
  - The winning address, direction and write data are latched at the end of cycle N.
  - mem_req=1 from cycle N+1.
- INSTR and DATA:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - mem_we=1 only in DATA with the latched Data_rd=0.
  - Port inputs are not re-sampled during the access.
- mem_ack seen in cycle M:
  - mem_req drops in cycle M+1.
  - The matching complete_* is 1 in cycle M+1 only.
  - For fetches and data reads, mem_rdata captured at M is driven on Instr_dout or Data_dout from M+1 and held until the next completion on that port. Data_dout is unchanged on writes.
  - FSM returns to IDLE in M+1.
- Minimum latency is request to complete = 2 cycles when mem_ack arrives in the first mem_req cycle.
- A request still asserted in the cycle of its complete_* pulse is re-evaluated in IDLE as a new access. Back-to-back accesses therefore have one IDLE turnaround cycle.
- Both requests rising in the same cycle: DATA is served first, then INSTR.
- mem_ack in IDLE is ignored.
- Timeout counter:
  - Counts the cycles mem_req is high without mem_ack.
  - If it reaches TIMEOUT: mem_req drops, the state goes to IDLE, the complete_* pulse is issued with the data output unchanged, and timeout_err sets.
  - timeout_err stays set until reset.
- There is exactly one outstanding memory access at any time.

Optional Feature:
Macro STARVE_GUARD_EN.
- Defined: a counter tracks consecutive DATA grants made while instrmem_rd=1. When it reaches STARVE_MAX, the next IDLE decision grants INSTR even if data_req=1. The counter clears on any INSTR grant and on reset.
- Not defined: strict data priority and no counter logic.

Test Plan:
- Reset with reset=0 for 3 cycles while instrmem_rd=1 and mem_ack=1 -> all outputs 0, mem_req stays 0 throughout.
- Fetch: pc=16'h3000, instrmem_rd=1, memory acks on its first request cycle with mem_rdata=16'h1234 -> complete_instr pulses 2 cycles after the request, Instr_dout=16'h1234, mem_we=0.
- Write: data_req=1, Data_rd=0, Data_addr=16'h4000, Data_din=16'hBEEF, ack after 3 cycles -> mem_we=1, mem_addr=16'h4000, mem_wdata=16'hBEEF for 3 cycles, then complete_data for exactly 1 cycle, Data_dout unchanged.
- Contention: data_req and instrmem_rd both rise in the same cycle -> DATA is served first, then after one IDLE cycle INSTR; complete_data precedes complete_instr.
- Timeout: memory never acks, TIMEOUT=64 -> mem_req high for exactly 64 cycles, then complete_* pulses, timeout_err=1 and stays set until reset.
- STARVE_GUARD_EN with STARVE_MAX=4, data_req and instrmem_rd held high -> grant order is 4 DATA, 1 INSTR, 4 DATA, and so on. Without the macro, INSTR is never granted.
